// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the matrix datapath arithmetic blocks.
// Holds the format constants, the field view of an FP32 word, the
// divider state type and small unpack helpers used by fp32_div.
package fp32_pkg;

    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_FRAC_W   = 23;
    localparam int FP32_MANT_W   = 24;
    localparam int DIV_Q_W       = 26;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Mantissa with the hidden bit; denormals carry a hidden bit of 0.
    function automatic logic [FP32_MANT_W-1:0] unpackMant(input fp32_t x);
        return {(x.exp != '0), x.frac};
    endfunction

    // Denormals behave as exponent 1; result is widened to 10 bits.
    function automatic logic [9:0] unpackExp(input fp32_t x);
        return (x.exp == '0) ? 10'd1 : {2'b00, x.exp};
    endfunction

    // Zero means both exponent and fraction are clear, sign ignored.
    function automatic logic isZero(input fp32_t x);
        return (x.exp == '0) && (x.frac == '0);
    endfunction

endpackage

// File: rtl/fp32_div_if.sv
// Operand/result handshake bundle for fp32_div.
// The master side supplies operands and consumes results; the slave
// side is the divider itself.
interface fp32_div_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output overflow
    );

endinterface

// File: rtl/fp32_lzc24.sv
// Combinational 24-bit leading-zero counter.
// An all-zero input reports 24, so a left shift by the count clears it.
module fp32_lzc24 (
    input  logic [23:0] value_i,
    output logic [4:0]  count_o
);

    // Scan upward so the highest set bit writes the count last and wins.
    always_comb begin
        count_o = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value_i[i]) begin
                count_o = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_div.sv
// Iterative truncating FP32 divider, one quotient bit per cycle.
// Operands are unpacked and pre-normalized when accepted, a restoring
// divide runs for DIV_Q_W cycles, and the result is normalized,
// truncated and range-checked on the final step before being held
// in DONE until the consumer takes it.
module fp32_div
    import fp32_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    fp32_div_if.slave  bus
);

    div_state_e state_q, state_d;

    logic [4:0]             cnt_q;
    logic [FP32_MANT_W:0]   rem_q;
    logic [FP32_MANT_W-1:0] mb_q;
    logic [DIV_Q_W-1:0]     quo_q;
    logic signed [9:0]      exp_q;
    logic                   sign_q;
    logic                   aZero_q;
    logic                   bZero_q;
    logic [31:0]            y_q;
    logic                   ovf_q;

    fp32_t opA;
    fp32_t opB;
    logic [FP32_MANT_W-1:0] maRaw;
    logic [FP32_MANT_W-1:0] mbRaw;
    logic [FP32_MANT_W-1:0] maNorm;
    logic [FP32_MANT_W-1:0] mbNorm;
    logic [4:0]             zA;
    logic [4:0]             zB;
    logic signed [9:0]      eaEff;
    logic signed [9:0]      ebEff;
    logic signed [9:0]      expCalc;

    logic                   accept;
    logic                   lastStep;
    logic                   remGe;
    logic [FP32_MANT_W:0]   remAfter;
    logic [FP32_MANT_W:0]   remNext;
    logic [DIV_Q_W-1:0]     quoNext;
    logic [FP32_FRAC_W-1:0] fracFin;
    logic signed [9:0]      expFin;
    logic [31:0]            resY;
    logic                   resOvf;

    assign opA      = bus.a;
    assign opB      = bus.b;
    assign maRaw    = unpackMant(opA);
    assign mbRaw    = unpackMant(opB);
    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign lastStep = (cnt_q == 5'(DIV_Q_W - 1));

    fp32_lzc24 u_lzcA (
        .value_i (maRaw),
        .count_o (zA)
    );

    fp32_lzc24 u_lzcB (
        .value_i (mbRaw),
        .count_o (zB)
    );

    // Pre-normalize both mantissas to have bit 23 set and form the biased
    // quotient exponent; zero operands shift to zero and are overridden later.
    always_comb begin
        maNorm  = maRaw << zA;
        mbNorm  = mbRaw << zB;
        eaEff   = signed'(unpackExp(opA) - {5'b0, zA});
        ebEff   = signed'(unpackExp(opB) - {5'b0, zB});
        expCalc = eaEff - ebEff + 10'sd127;
    end

    // One restoring step: subtract when the divisor fits, record the bit,
    // then shift the partial remainder up for the next step.
    always_comb begin
        remGe    = (rem_q >= {1'b0, mb_q});
        remAfter = remGe ? (rem_q - {1'b0, mb_q}) : rem_q;
        remNext  = remAfter << 1;
        quoNext  = {quo_q[DIV_Q_W-2:0], remGe};
    end

    // Normalize the full quotient (it lies in [2^24, 2^26)), truncate, and
    // pick the packed result by zero-operand and exponent-range priority.
    always_comb begin
        if (quoNext[DIV_Q_W-1]) begin
            fracFin = quoNext[DIV_Q_W-2:2];
            expFin  = exp_q;
        end else begin
            fracFin = quoNext[DIV_Q_W-3:1];
            expFin  = exp_q - 10'sd1;
        end
        if (bZero_q) begin
            resY   = {sign_q, 8'hFF, 23'h0};
            resOvf = 1'b1;
        end else if (aZero_q) begin
            resY   = {sign_q, 31'h0};
            resOvf = 1'b0;
        end else if (expFin >= 10'sd255) begin
            resY   = {sign_q, 8'hFF, 23'h0};
            resOvf = 1'b1;
        end else if (expFin <= 10'sd0) begin
            resY   = {sign_q, 31'h0};
            resOvf = 1'b1;
        end else begin
            resY   = {sign_q, expFin[7:0], fracFin};
            resOvf = 1'b0;
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, count steps in CALC, wait in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = CALC;
            CALC:    if (lastStep)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state; result comes from registers.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.y         = y_q;
        bus.overflow  = ovf_q;
    end

    // Datapath registers: load operands on accept, iterate in CALC and
    // capture the packed result on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            aZero_q <= 1'b0;
            bZero_q <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            rem_q   <= {1'b0, maNorm};
            mb_q    <= mbNorm;
            quo_q   <= '0;
            exp_q   <= expCalc;
            sign_q  <= opA.sign ^ opB.sign;
            aZero_q <= isZero(opA);
            bZero_q <= isZero(opB);
        end else if (state_q == CALC) begin
            rem_q <= remNext;
            quo_q <= quoNext;
            if (lastStep) begin
                cnt_q <= '0;
                y_q   <= resY;
                ovf_q <= resOvf;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_div.sv
// Bench for fp32_div: directed vector table, handshake and reset
// sequences, then random operands against an arithmetic reference model.
module tb_fp32_div;

    logic clk;
    logic rst_n;
    int   vecCount  = 0;
    int   missCount = 0;

    fp32_div_if busIf ();

    fp32_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expY;
        logic        expOvf;
    } vec_t;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vecCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic reportTimeout(input string name);
        vecCount++;
        missCount++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, want event", name);
    endtask

    // Reference: real arithmetic on unpacked fields, normalized by loop,
    // quotient by one wide integer division.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] y, output logic ovf);
        logic        s;
        longint      ma, mb, q;
        int          ea, eb, e, ef;
        logic [22:0] fr;
        s = a[31] ^ b[31];
        if (b[30:0] == 31'h0) begin
            y = {s, 8'hFF, 23'h0}; ovf = 1'b1;
        end else if (a[30:0] == 31'h0) begin
            y = {s, 31'h0}; ovf = 1'b0;
        end else begin
            ea = (a[30:23] == 8'h0) ? 1 : int'(a[30:23]);
            eb = (b[30:23] == 8'h0) ? 1 : int'(b[30:23]);
            ma = longint'({a[30:23] != 8'h0, a[22:0]});
            mb = longint'({b[30:23] != 8'h0, b[22:0]});
            while (ma < (longint'(1) << 23)) begin ma = ma * 2; ea--; end
            while (mb < (longint'(1) << 23)) begin mb = mb * 2; eb--; end
            e = ea - eb + 127;
            q = (ma * (longint'(1) << 25)) / mb;
            if (q >= (longint'(1) << 25)) begin
                fr = 23'((q >> 2) & longint'(32'h007FFFFF)); ef = e;
            end else begin
                fr = 23'((q >> 1) & longint'(32'h007FFFFF)); ef = e - 1;
            end
            if (ef >= 255) begin
                y = {s, 8'hFF, 23'h0}; ovf = 1'b1;
            end else if (ef <= 0) begin
                y = {s, 31'h0}; ovf = 1'b1;
            end else begin
                y = {s, 8'(ef), fr}; ovf = 1'b0;
            end
        end
    endfunction

    // Full transaction: wait for in_ready, accept, scramble the operand
    // inputs, wait for out_valid while counting cycles, then consume.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] y, output logic ovf, output int lat);
        int guard = 0;
        while (!busIf.in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) reportTimeout("inReadyWait");
        busIf.a        = a;
        busIf.b        = b;
        busIf.in_valid = 1'b1;
        @(posedge clk); #1;
        busIf.in_valid = 1'b0;
        busIf.a        = $urandom;
        busIf.b        = $urandom;
        checkOutput("inReadyBusy", 32'(busIf.in_ready), 32'd0);
        lat = 0;
        while (!busIf.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 40) reportTimeout("outValidWait");
        y   = busIf.y;
        ovf = busIf.overflow;
        busIf.out_ready = 1'b1;
        @(posedge clk); #1;
        busIf.out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [31:0] y, ry, ra, rb;
        logic        ovf, rovf;
        int          lat;

        vecs[0] = '{"div6by2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1] = '{"div1by3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        vecs[2] = '{"negHalf",    32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0};
        vecs[3] = '{"divByZero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[4] = '{"expOver",    32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1};
        vecs[5] = '{"zeroNum",    32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6] = '{"denormNum",  32'h00400000, 32'h3F000000, 32'h00800000, 1'b0};
        vecs[7] = '{"underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 1'b1};
        vecs[8] = '{"zeroByZero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[9] = '{"negZeroDiv", 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1};

        rst_n           = 1'b0;
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        busIf.a         = '0;
        busIf.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOutValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("rstInReady",  32'(busIf.in_ready),  32'd1);
        checkOutput("rstY",        busIf.y,              32'h0);
        checkOutput("rstOvf",      32'(busIf.overflow),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, y, ovf, lat);
            checkOutput({vecs[i].name, "_y"},   y,         vecs[i].expY);
            checkOutput({vecs[i].name, "_ovf"}, 32'(ovf),  32'(vecs[i].expOvf));
            checkOutput({vecs[i].name, "_lat"}, 32'(lat),  32'd26);
        end

        $display("[TB] output backpressure");
        busIf.a = 32'h40C00000; busIf.b = 32'h40000000; busIf.in_valid = 1'b1;
        @(posedge clk); #1;
        busIf.in_valid = 1'b0;
        lat = 0;
        while (!busIf.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (lat >= 40) reportTimeout("holdOutValid");
        for (int i = 0; i < 10; i++) begin
            busIf.in_valid = 1'b1;
            busIf.a = $urandom; busIf.b = $urandom;
            @(posedge clk); #1;
            checkOutput("holdY",        busIf.y,               32'h40400000);
            checkOutput("holdInReady",  32'(busIf.in_ready),   32'd0);
            checkOutput("holdOutValid", 32'(busIf.out_valid),  32'd1);
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        @(posedge clk); #1;
        busIf.out_ready = 1'b0;
        checkOutput("releaseInReady",  32'(busIf.in_ready),  32'd1);
        checkOutput("releaseOutValid", 32'(busIf.out_valid), 32'd0);
        applyStimulus(32'h3F800000, 32'h40400000, y, ovf, lat);
        checkOutput("afterHoldY", y, 32'h3EAAAAAA);

        $display("[TB] reset during CALC");
        busIf.a = 32'h3F800000; busIf.b = 32'h40400000; busIf.in_valid = 1'b1;
        @(posedge clk); #1;
        busIf.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("midRstInReady",  32'(busIf.in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("postRstOutValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("postRstInReady",  32'(busIf.in_ready),  32'd1);
        checkOutput("postRstY",        busIf.y,              32'h0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("postRstIdle", 32'(busIf.out_valid), 32'd0);
        applyStimulus(32'h40C00000, 32'h40000000, y, ovf, lat);
        checkOutput("postRstDivY",   y,        32'h40400000);
        checkOutput("postRstDivLat", 32'(lat), 32'd26);

        $display("[TB] random back-to-back operands");
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) ra[30:23] = 8'h00;
            if ($urandom_range(7) == 0) rb[30:23] = 8'h00;
            if ($urandom_range(15) == 0) ra[30:0] = 31'h0;
            if ($urandom_range(15) == 0) rb[30:0] = 31'h0;
            if ($urandom_range(1) == 0) rb[30:23] = 8'($urandom_range(100, 150));
            refDiv(ra, rb, ry, rovf);
            applyStimulus(ra, rb, y, ovf, lat);
            checkOutput("randY",   y,        ry);
            checkOutput("randOvf", 32'(ovf), 32'(rovf));
            checkOutput("randLat", 32'(lat), 32'd26);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/fp32_div.md
Name: fp32_div

Overview:
- Iterative FP32 divider, the inverse operation of the team's combinational truncating FP32 multiplier.
- Shares its number conventions:
  - denormals are treated as exp=1 with hidden bit 0;
  - no rounding; the result fraction is truncated after normalization;
  - a single overflow flag is raised on exponent out-of-range.
- Restoring division, one quotient bit per cycle, behind valid/ready handshakes. Sits in the matrix datapath next to fp32_mul for normalization/scaling.

Parameters:
- None. Format is fixed FP32; widths and bias come from the shared package.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  32  dividend, FP32
- b  in  32  divisor, FP32
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- y  out  32  quotient a/b, FP32, truncated
- overflow  out  1  exponent out of range or divide-by-zero; qualified by out_valid

Behaviour:
- Reset: rst_n low at any time, including mid-operation, forces IDLE, out_valid=0, y=0, overflow=0, counter=0. The operation in flight is discarded.
- States:
  - IDLE: in_ready=1. in_valid=1 accepts the operands at that edge and moves to CALC.
  - CALC: 26 cycles. At the final CALC edge, y and overflow are registered and the state moves to DONE.
  - DONE: out_valid=1, y and overflow stable. out_ready=1 returns to IDLE at that edge.
- Latency: accept edge at cycle 0, out_valid high from cycle 26. in_ready is low from cycle 1 until the cycle after result acceptance. No pipelining, one operation in flight.
- Operand unpack (at accept):
  - s = a[31]^b[31].
  - e = (raw exp==0) ? 1 : raw exp.
  - m = {exp!=0, frac}, 24 bits.
  - Exp 255 is an ordinary exponent; there is no NaN/Inf handling.
- Pre-normalize (at accept): for nonzero operands, a combinational leading-zero count z shifts m left by z so m[23]=1, and sets e_eff = e - z (10-bit signed).
- Exponent: E = ea_eff - eb_eff + 127, 10-bit signed.
- Division:
  - Remainder R is 25 bits, initialized to ma.
  - Each CALC cycle: if R >= mb, set q bit=1 and R = R - mb; then R <<= 1.
  - Quotient bits shift into q[25:0] MSB-first, giving q = floor(ma * 2^25 / mb).
- Normalize and truncate:
  - q[25]=1: frac = q[24:2], Ef = E.
  - otherwise (q[24]=1): frac = q[23:1], Ef = E - 1.
- Result priority (first match wins):
  1. b zero: y = {s, 8'hFF, 0}, overflow=1.
  2. a zero: y = {s, 0, 0}, overflow=0.
  3. Ef >= 255: y = {s, 8'hFF, 0}, overflow=1.
  4. Ef <= 0: y = {s, 0, 0}, overflow=1. Flush, no denormal output.
  5. Else: y = {s, Ef[7:0], frac}, overflow=0.
- Special cases still take the full 26-cycle latency.
- Simultaneous events:
  - in_valid outside IDLE is ignored; operands are not captured.
  - out_ready outside DONE is ignored.
  - a and b are sampled only at the accept edge; later changes have no effect.

Decomposition:
- fp32_pkg holds:
  - constants FP32_EXP_BIAS=127, FP32_EXP_W=8, FP32_FRAC_W=23, FP32_MANT_W=24, DIV_Q_W=26;
  - packed struct fp32_t {sign, exp, frac};
  - enum div_state_e {IDLE, CALC, DONE}.
- Sub-module fp32_lzc24 (combinational 24-bit leading-zero count, 5-bit output). It is instantiated twice, for dividend and divisor, and is reusable by later adders.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> y=0x40400000, overflow=0, out_valid exactly 26 cycles after the accept edge.
- 0x3F800000 / 0x40400000 (1/3) -> y=0x3EAAAAAA (truncated, not 0x3EAAAAAB). Sign case: 0xBF800000 / 0x40000000 -> 0xBF000000.
- Division by zero and overflow:
  - 0x3F800000 / 0x00000000 -> y=0x7F800000, overflow=1.
  - 0x7F000000 / 0x00800000 -> y=0x7F800000, overflow=1.
  - 0x00000000 / 0x40000000 -> y=0x00000000, overflow=0.
- Denormal dividend: 0x00400000 / 0x3F000000 -> y=0x00800000, overflow=0. Underflow: 0x00800000 / 0x7F000000 -> y=0, overflow=1.
- Handshake:
  - hold out_ready=0 for 10 cycles after out_valid: y stable, in_ready=0, new in_valid ignored;
  - release out_ready: in_ready=1 next cycle;
  - back-to-back operations produce no result corruption.
- Reset: assert rst_n=0 at CALC cycle 12 -> out_valid=0 and in_ready=1 immediately after release. The next operation 0x40C00000 / 0x40000000 returns 0x40400000.
